mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 26 ++
 rtl/mem_lane_align.sv | 55 +++++
 rtl/mem_access_unit.sv | 157 +++++++++++++++
 tb/tb_mem_access_unit.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared size/state encodings and lane helper
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BEAT0 = 3'd1,
    ST_WAIT0 = 3'd2,
    ST_BEAT1 = 3'd3,
    ST_WAIT1 = 3'd4,
    ST_RESP  = 3'd5
  } state_e;

  // True when an access of 2**size bytes starting at lane 'offset' spills past a bus word.
  function automatic logic f_crosses(input int unsigned offset, input logic [1:0] size,
                                     input int unsigned be);
    return (offset + (32'd1 << size)) > be;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane mask, store shift and load extract/extend
module mem_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter int DW = 32,
  localparam int BE = DW / 8,
  localparam int OW = $clog2(BE)
) (
  input  logic [OW-1:0]   i_offset,
  input  logic [1:0]      i_size,
  input  logic            i_unsigned,
  input  logic [DW-1:0]   i_wdata,
  input  logic [DW-1:0]   i_rdata_lo,
  input  logic [DW-1:0]   i_rdata_hi,
  output logic [2*BE-1:0] o_mask,
  output logic [2*DW-1:0] o_wdata_wide,
  output logic [DW-1:0]   o_rdata
);

  logic [2*BE-1:0] w_ones;
  logic [DW-1:0]   w_shifted;
  logic            w_msb;
  int              w_nbits;

  always_comb begin
    w_ones = '0;
    for (int i = 0; i < 2*BE; i++) begin
      if (i < (1 << i_size)) w_ones[i] = 1'b1;
    end
  end

  assign o_mask       = w_ones << i_offset;
  assign o_wdata_wide = {{DW{1'b0}}, i_wdata} << {i_offset, 3'b000};
  assign w_shifted    = DW'({i_rdata_hi, i_rdata_lo} >> {i_offset, 3'b000});

  always_comb begin
    w_nbits = DW;
    w_msb   = w_shifted[DW-1];
    case (size_e'(i_size))
      SZ_BYTE: begin w_nbits = 8;  w_msb = w_shifted[7];  end
      SZ_HALF: begin w_nbits = 16; w_msb = w_shifted[15]; end
      SZ_WORD: begin w_nbits = 32; w_msb = w_shifted[31]; end
      default: begin w_nbits = DW; w_msb = w_shifted[DW-1]; end
    endcase
  end

  // Bits above the access width are filled with zero or the access's top bit.
  always_comb begin
    o_rdata = '0;
    for (int i = 0; i < DW; i++) begin
      o_rdata[i] = (i < w_nbits) ? w_shifted[i] : (w_msb & ~i_unsigned);
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-outstanding load/store unit with optional
// two-beat split of line-crossing accesses
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DW       = 32,
  parameter int AW       = 32,
  parameter int SPLIT_EN = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   req_addr,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [DW-1:0]   req_wdata,
  output logic            resp_valid,
  output logic [DW-1:0]   resp_rdata,
  output logic            resp_err,
  output logic            bus_req,
  input  logic            bus_gnt,
  output logic [AW-1:0]   bus_addr,
  output logic            bus_we,
  output logic [DW/8-1:0] bus_byteen,
  output logic [DW-1:0]   bus_wdata,
  input  logic            bus_rvalid,
  input  logic [DW-1:0]   bus_rdata,
  input  logic            bus_err
);

  localparam int BE = DW / 8;
  localparam int OW = $clog2(BE);

  state_e          r_state, w_next;
  logic [AW-1:0]   r_addr;
  logic            r_we, r_unsigned, r_cross, r_err;
  logic [1:0]      r_size;
  logic [DW-1:0]   r_wdata, r_beat0, r_rdata;

  logic            w_accept, w_req_cross, w_req_bad;
  logic [AW-1:0]   w_base;
  logic [DW-1:0]   w_rd_lo, w_rd_hi, w_load;
  logic [2*BE-1:0] w_mask;
  logic [2*DW-1:0] w_wide;

  assign w_accept    = req_valid && req_ready;
  assign w_req_cross = f_crosses(32'(req_addr[OW-1:0]), req_size, BE);
  assign w_req_bad   = ((req_size == SZ_DWORD) && (DW == 32)) || (w_req_cross && (SPLIT_EN == 0));
  assign w_base      = {r_addr[AW-1:OW], {OW{1'b0}}};

  // In WAIT1 the held first beat becomes the low word of the two-beat window.
  assign w_rd_lo = (r_state == ST_WAIT1) ? r_beat0 : bus_rdata;
  assign w_rd_hi = (r_state == ST_WAIT1) ? bus_rdata : '0;

  mem_lane_align #(.DW(DW)) u_align (
    .i_offset     (r_addr[OW-1:0]),
    .i_size       (r_size),
    .i_unsigned   (r_unsigned),
    .i_wdata      (r_wdata),
    .i_rdata_lo   (w_rd_lo),
    .i_rdata_hi   (w_rd_hi),
    .o_mask       (w_mask),
    .o_wdata_wide (w_wide),
    .o_rdata      (w_load)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = w_req_bad ? ST_RESP : ST_BEAT0;
      ST_BEAT0: if (bus_gnt) w_next = ST_WAIT0;
      ST_WAIT0: if (bus_rvalid) w_next = (r_cross && !bus_err) ? ST_BEAT1 : ST_RESP;
      ST_BEAT1: if (bus_gnt) w_next = ST_WAIT1;
      ST_WAIT1: if (bus_rvalid) w_next = ST_RESP;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (r_state == ST_IDLE) && reset_n;
    bus_req    = 1'b0;
    bus_addr   = '0;
    bus_we     = 1'b0;
    bus_byteen = '0;
    bus_wdata  = '0;
    case (r_state)
      ST_BEAT0: begin
        bus_req    = 1'b1;
        bus_addr   = w_base;
        bus_we     = r_we;
        bus_byteen = w_mask[BE-1:0];
        bus_wdata  = w_wide[DW-1:0];
      end
      ST_BEAT1: begin
        bus_req    = 1'b1;
        bus_addr   = w_base + AW'(BE);
        bus_we     = r_we;
        bus_byteen = w_mask[2*BE-1:BE];
        bus_wdata  = w_wide[2*DW-1:DW];
      end
      default: ;
    endcase
    resp_valid = (r_state == ST_RESP);
    resp_err   = resp_valid && r_err;
    resp_rdata = resp_valid ? r_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_size     <= 2'd0;
      r_unsigned <= 1'b0;
      r_wdata    <= '0;
      r_cross    <= 1'b0;
      r_err      <= 1'b0;
      r_beat0    <= '0;
      r_rdata    <= '0;
    end else begin
      if (w_accept) begin
        r_addr     <= req_addr;
        r_we       <= req_we;
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_wdata    <= req_wdata;
        r_cross    <= w_req_cross;
        r_err      <= w_req_bad;
        r_rdata    <= '0;
      end
      if (r_state == ST_WAIT0 && bus_rvalid) begin
        r_beat0 <= bus_rdata;
        if (bus_err) begin
          r_err   <= 1'b1;
          r_rdata <= '0;
        end else if (!r_cross) begin
          r_rdata <= r_we ? '0 : w_load;
        end
      end
      if (r_state == ST_WAIT1 && bus_rvalid) begin
        if (bus_err) begin
          r_err   <= 1'b1;
          r_rdata <= '0;
        end else begin
          r_rdata <= r_we ? '0 : w_load;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed table, byte-level reference model and
// reset/error sequences for mem_access_unit
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, n_req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        bus_gnt, bus_rvalid, bus_err;
  logic [31:0] bus_rdata;

  logic        req_ready, resp_valid, resp_err, bus_req, bus_we;
  logic [31:0] resp_rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_byteen;

  logic        n_req_ready, n_resp_valid, n_resp_err, n_bus_req, n_bus_we;
  logic [31:0] n_resp_rdata, n_bus_addr, n_bus_wdata;
  logic [3:0]  n_bus_byteen;

  always #5 clk = ~clk;

  mem_access_unit #(.DW(32), .AW(32), .SPLIT_EN(1)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_addr(bus_addr), .bus_we(bus_we),
    .bus_byteen(bus_byteen), .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  mem_access_unit #(.DW(32), .AW(32), .SPLIT_EN(0)) dut_ns (
    .clk(clk), .reset_n(reset_n), .req_valid(n_req_valid), .req_ready(n_req_ready),
    .req_addr(req_addr), .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .resp_valid(n_resp_valid), .resp_rdata(n_resp_rdata), .resp_err(n_resp_err),
    .bus_req(n_bus_req), .bus_gnt(bus_gnt), .bus_addr(n_bus_addr), .bus_we(n_bus_we),
    .bus_byteen(n_bus_byteen), .bus_wdata(n_bus_wdata), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observed transaction
  logic [31:0] g_addr[2], g_wd[2];
  logic [3:0]  g_be[2];
  logic        g_we[2];
  int          g_nb, g_lat;
  logic [31:0] g_rdata;
  logic        g_err, g_timeout, g_unstable;

  // Expected transaction
  logic [31:0] m_addr[2], m_wd[2];
  logic [3:0]  m_be[2];
  logic        m_we[2];
  int          m_nb;
  logic [31:0] m_rdata;
  logic        m_err;

  // Acts as the CPU for one request and as a bus slave for its beats.
  task automatic run_txn(input logic [31:0] a, input logic w, input logic [1:0] s, input logic u,
                         input logic [31:0] wd, input logic [31:0] rd0, input logic [31:0] rd1,
                         input logic e0, input logic e1, input int gdly, input int rdly);
    int  cyc, wn, bi;
    bit  done;
    g_nb = 0; g_lat = -1; g_rdata = '0; g_err = 1'b0; g_unstable = 1'b0;
    g_timeout = !req_ready;
    done = 0; wn = 0;
    for (int k = 0; k < 2; k++) begin
      g_addr[k] = '0; g_wd[k] = '0; g_be[k] = '0; g_we[k] = 1'b0;
    end
    req_valid = 1'b1; req_addr = a; req_we = w; req_size = s; req_unsigned = u; req_wdata = wd;
    tick();
    cyc = 1;
    req_valid = 1'b0; req_addr = $urandom; req_we = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_wdata = $urandom;
    while (!done && cyc < 100) begin
      bi = (g_nb < 2) ? g_nb : 1;
      if (resp_valid) begin
        g_rdata = resp_rdata; g_err = resp_err; g_lat = cyc; done = 1;
      end else if (bus_req) begin
        if (wn == 0) begin
          g_addr[bi] = bus_addr; g_be[bi] = bus_byteen; g_wd[bi] = bus_wdata; g_we[bi] = bus_we;
        end else if (bus_addr !== g_addr[bi] || bus_byteen !== g_be[bi] ||
                     bus_wdata !== g_wd[bi] || bus_we !== g_we[bi]) begin
          g_unstable = 1'b1;
        end
        if (wn >= gdly) begin
          bus_gnt = 1'b1;
          tick(); cyc++;
          bus_gnt = 1'b0;
          if (bus_req) g_unstable = 1'b1;
          for (int k = 0; k < rdly; k++) begin tick(); cyc++; end
          bus_rvalid = 1'b1;
          bus_rdata  = (g_nb == 0) ? rd0 : rd1;
          bus_err    = (g_nb == 0) ? e0 : e1;
          g_nb++; wn = 0;
          tick(); cyc++;
          bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
        end else begin
          wn++;
          tick(); cyc++;
        end
      end else begin
        tick(); cyc++;
      end
    end
    if (!done) g_timeout = 1'b1;
    tick();
  endtask

  // Byte-lane reference: each request byte j lives in lane offset+j of a two-word window.
  task automatic model(input logic [31:0] a, input logic w, input logic [1:0] s, input logic u,
                       input logic [31:0] wd, input logic [31:0] rd0, input logic [31:0] rd1,
                       input logic e0, input logic e1);
    int off, n, bt, ln, idx, lane;
    off = int'(a[1:0]);
    n   = 1 << s;
    for (int k = 0; k < 2; k++) begin
      m_addr[k] = '0; m_wd[k] = '0; m_be[k] = '0; m_we[k] = 1'b0;
    end
    m_rdata = '0; m_err = 1'b0; m_nb = 0;
    if (s == 2'd3) begin
      m_err = 1'b1;
      return;
    end
    m_nb = (off + n > 4) ? 2 : 1;
    if (e0) m_nb = 1;
    for (int k = 0; k < 8; k++) begin
      bt = k / 4; ln = k % 4; idx = k - off;
      if (bt < m_nb) begin
        m_addr[bt] = {a[31:2], 2'b00} + 32'(4 * bt);
        m_we[bt]   = w;
        if (idx >= 0 && idx < n) m_be[bt][ln] = 1'b1;
        if (idx >= 0 && idx < 4) m_wd[bt][ln*8 +: 8] = wd[idx*8 +: 8];
      end
    end
    m_err = e0 || (m_nb == 2 && e1);
    if (!m_err && !w) begin
      for (int j = 0; j < n; j++) begin
        lane = off + j;
        if (lane < 4) m_rdata[j*8 +: 8] = rd0[lane*8 +: 8];
        else          m_rdata[j*8 +: 8] = rd1[(lane-4)*8 +: 8];
      end
      if (!u && n < 4 && m_rdata[8*n-1]) begin
        for (int j = n; j < 4; j++) m_rdata[j*8 +: 8] = 8'hFF;
      end
    end
  endtask

  typedef struct {
    logic [31:0] a;  logic w; logic [1:0] s; logic u;
    logic [31:0] wd, rd0, rd1;
    int          nb;
    logic [31:0] ad0, ad1;
    logic [3:0]  be0, be1;
    logic [31:0] wd0, wd1, rdat;
    logic        err;
    int          lat;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{a:32'h1003, w:1'b0, s:2'd0, u:1'b0, wd:32'h0, rd0:32'h80FF_FFFF, rd1:32'h0, nb:1,
               ad0:32'h1000, ad1:32'h0, be0:4'b1000, be1:4'b0000, wd0:32'h0, wd1:32'h0,
               rdat:32'hFFFF_FF80, err:1'b0, lat:3};
    tbl[1] = '{a:32'h2002, w:1'b1, s:2'd1, u:1'b0, wd:32'h0000_BEEF, rd0:32'h0, rd1:32'h0, nb:1,
               ad0:32'h2000, ad1:32'h0, be0:4'b1100, be1:4'b0000, wd0:32'hBEEF_0000, wd1:32'h0,
               rdat:32'h0, err:1'b0, lat:3};
    tbl[2] = '{a:32'h3002, w:1'b0, s:2'd2, u:1'b1, wd:32'h0, rd0:32'h1122_3344, rd1:32'h5566_7788, nb:2,
               ad0:32'h3000, ad1:32'h3004, be0:4'b1100, be1:4'b0011, wd0:32'h0, wd1:32'h0,
               rdat:32'h7788_1122, err:1'b0, lat:5};
    tbl[3] = '{a:32'h4001, w:1'b0, s:2'd1, u:1'b0, wd:32'h0, rd0:32'h12F0_0F34, rd1:32'h0, nb:1,
               ad0:32'h4000, ad1:32'h0, be0:4'b0110, be1:4'b0000, wd0:32'h0, wd1:32'h0,
               rdat:32'hFFFF_F00F, err:1'b0, lat:3};
    tbl[4] = '{a:32'h5000, w:1'b0, s:2'd3, u:1'b0, wd:32'h0, rd0:32'h0, rd1:32'h0, nb:0,
               ad0:32'h0, ad1:32'h0, be0:4'b0000, be1:4'b0000, wd0:32'h0, wd1:32'h0,
               rdat:32'h0, err:1'b1, lat:1};
    tbl[5] = '{a:32'h6001, w:1'b1, s:2'd0, u:1'b0, wd:32'hAABB_CCDD, rd0:32'h0, rd1:32'h0, nb:1,
               ad0:32'h6000, ad1:32'h0, be0:4'b0010, be1:4'b0000, wd0:32'hBBCC_DD00, wd1:32'h0,
               rdat:32'h0, err:1'b0, lat:3};
    tbl[6] = '{a:32'h7003, w:1'b1, s:2'd2, u:1'b0, wd:32'h1122_3344, rd0:32'h0, rd1:32'h0, nb:2,
               ad0:32'h7000, ad1:32'h7004, be0:4'b1000, be1:4'b0111, wd0:32'h4400_0000, wd1:32'h0011_2233,
               rdat:32'h0, err:1'b0, lat:5};
    tbl[7] = '{a:32'h8003, w:1'b0, s:2'd1, u:1'b1, wd:32'h0, rd0:32'hAB00_0000, rd1:32'h0000_00CD, nb:2,
               ad0:32'h8000, ad1:32'h8004, be0:4'b1000, be1:4'b0001, wd0:32'h0, wd1:32'h0,
               rdat:32'h0000_CDAB, err:1'b0, lat:5};

    reset_n = 1'b0; req_valid = 1'b0; n_req_valid = 1'b0; req_we = 1'b0; req_unsigned = 1'b0;
    req_size = 2'd0; req_addr = '0; req_wdata = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = '0;

    tick(); tick();
    chk("rst.req_ready", 32'(req_ready), 32'd0);
    chk("rst.bus_req", 32'(bus_req), 32'd0);
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.resp_err", 32'(resp_err), 32'd0);
    chk("rst.resp_rdata", resp_rdata, 32'd0);
    chk("rst.bus_byteen", 32'(bus_byteen), 32'd0);
    chk("rst.bus_we", 32'(bus_we), 32'd0);
    chk("rst.bus_addr", bus_addr, 32'd0);
    chk("rst.bus_wdata", bus_wdata, 32'd0);
    reset_n = 1'b1;
    tick();
    chk("rst.req_ready_after", 32'(req_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i].a, tbl[i].w, tbl[i].s, tbl[i].u, tbl[i].wd, tbl[i].rd0, tbl[i].rd1,
              1'b0, 1'b0, 0, 0);
      chk($sformatf("tbl%0d.timeout", i), 32'(g_timeout), 32'd0);
      chk($sformatf("tbl%0d.nbeats", i), 32'(g_nb), 32'(tbl[i].nb));
      chk($sformatf("tbl%0d.addr0", i), g_addr[0], tbl[i].ad0);
      chk($sformatf("tbl%0d.addr1", i), g_addr[1], tbl[i].ad1);
      chk($sformatf("tbl%0d.be0", i), 32'(g_be[0]), 32'(tbl[i].be0));
      chk($sformatf("tbl%0d.be1", i), 32'(g_be[1]), 32'(tbl[i].be1));
      chk($sformatf("tbl%0d.wd0", i), g_wd[0], tbl[i].wd0);
      chk($sformatf("tbl%0d.wd1", i), g_wd[1], tbl[i].wd1);
      chk($sformatf("tbl%0d.we0", i), 32'(g_we[0]), (tbl[i].nb > 0) ? 32'(tbl[i].w) : 32'd0);
      chk($sformatf("tbl%0d.rdata", i), g_rdata, tbl[i].rdat);
      chk($sformatf("tbl%0d.err", i), 32'(g_err), 32'(tbl[i].err));
      chk($sformatf("tbl%0d.latency", i), 32'(g_lat), 32'(tbl[i].lat));
      chk($sformatf("tbl%0d.unstable", i), 32'(g_unstable), 32'd0);
    end

    for (int i = 0; i < 80; i++) begin
      logic [31:0] a, wd, rd0, rd1;
      logic        w, u, e0, e1;
      logic [1:0]  s;
      int          gd, rdl;
      a = $urandom; wd = $urandom; rd0 = $urandom; rd1 = $urandom;
      w = 1'($urandom); u = 1'($urandom); s = 2'($urandom);
      e0 = ($urandom_range(0, 7) == 0); e1 = ($urandom_range(0, 7) == 0);
      gd = $urandom_range(0, 3); rdl = $urandom_range(0, 2);
      model(a, w, s, u, wd, rd0, rd1, e0, e1);
      run_txn(a, w, s, u, wd, rd0, rd1, e0, e1, gd, rdl);
      chk($sformatf("rnd%0d.timeout", i), 32'(g_timeout), 32'd0);
      chk($sformatf("rnd%0d.nbeats", i), 32'(g_nb), 32'(m_nb));
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("rnd%0d.addr%0d", i, k), g_addr[k], m_addr[k]);
        chk($sformatf("rnd%0d.be%0d", i, k), 32'(g_be[k]), 32'(m_be[k]));
        chk($sformatf("rnd%0d.wd%0d", i, k), g_wd[k], m_wd[k]);
        chk($sformatf("rnd%0d.we%0d", i, k), 32'(g_we[k]), 32'(m_we[k]));
      end
      chk($sformatf("rnd%0d.rdata", i), g_rdata, m_rdata);
      chk($sformatf("rnd%0d.err", i), 32'(g_err), 32'(m_err));
      chk($sformatf("rnd%0d.unstable", i), 32'(g_unstable), 32'd0);
    end

    // Split store whose first beat errors, with grant withheld for five cycles.
    run_txn(32'h9002, 1'b1, 2'd2, 1'b0, 32'hCAFE_F00D, 32'h0, 32'h0, 1'b1, 1'b0, 5, 1);
    chk("berr0.nbeats", 32'(g_nb), 32'd1);
    chk("berr0.addr0", g_addr[0], 32'h9000);
    chk("berr0.be0", 32'(g_be[0]), 32'h0000_000C);
    chk("berr0.wd0", g_wd[0], 32'hF00D_0000);
    chk("berr0.err", 32'(g_err), 32'd1);
    chk("berr0.rdata", g_rdata, 32'd0);
    chk("berr0.unstable", 32'(g_unstable), 32'd0);

    run_txn(32'hA001, 1'b0, 2'd2, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 0, 0);
    chk("berr1.nbeats", 32'(g_nb), 32'd2);
    chk("berr1.err", 32'(g_err), 32'd1);
    chk("berr1.rdata", g_rdata, 32'd0);

    // Crossing request on the non-splitting instance errors at once without bus activity.
    req_addr = 32'h3002; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b1; req_wdata = '0;
    chk("nosplit.ready", 32'(n_req_ready), 32'd1);
    n_req_valid = 1'b1;
    tick();
    n_req_valid = 1'b0;
    chk("nosplit.resp_valid", 32'(n_resp_valid), 32'd1);
    chk("nosplit.resp_err", 32'(n_resp_err), 32'd1);
    chk("nosplit.rdata", n_resp_rdata, 32'd0);
    chk("nosplit.bus_req", 32'(n_bus_req), 32'd0);
    tick();
    chk("nosplit.resp_drop", 32'(n_resp_valid), 32'd0);
    chk("nosplit.ready_again", 32'(n_req_ready), 32'd1);
    chk("nosplit.main_idle", 32'(bus_req), 32'd0);

    // Reset while waiting on the second beat; the late read beat must be ignored.
    begin
      int pulses;
      req_addr = 32'hB002; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      chk("rstmid.beat0", 32'(bus_req), 32'd1);
      bus_gnt = 1'b1;
      tick();
      bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
      tick();
      bus_rvalid = 1'b0;
      chk("rstmid.beat1", 32'(bus_req), 32'd1);
      chk("rstmid.beat1_addr", bus_addr, 32'hB004);
      bus_gnt = 1'b1;
      tick();
      bus_gnt = 1'b0;
      reset_n = 1'b0;
      tick();
      chk("rstmid.bus_req", 32'(bus_req), 32'd0);
      chk("rstmid.resp_valid", 32'(resp_valid), 32'd0);
      chk("rstmid.ready_in_reset", 32'(req_ready), 32'd0);
      reset_n = 1'b1;
      bus_rvalid = 1'b1; bus_rdata = 32'h9ABC_DEF0;
      tick();
      bus_rvalid = 1'b0;
      chk("rstmid.ready_after", 32'(req_ready), 32'd1);
      pulses = 0;
      for (int k = 0; k < 4; k++) begin
        if (resp_valid || bus_req) pulses++;
        tick();
      end
      chk("rstmid.no_activity", 32'(pulses), 32'd0);
    end

    run_txn(tbl[2].a, tbl[2].w, tbl[2].s, tbl[2].u, tbl[2].wd, tbl[2].rd0, tbl[2].rd1,
            1'b0, 1'b0, 0, 0);
    chk("post_rst.rdata", g_rdata, 32'h7788_1122);
    chk("post_rst.latency", 32'(g_lat), 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
